// File: rtl/mips_alu_exec_unit.sv
// Execute-stage ALU control decode, 32-bit ALU with zero flag, PC+4 and branch-target adders.
// Datapath outputs are combinational (0 cycles); result_q_o/zero_q_o register one cycle later; no backpressure.
module mips_alu_exec_unit (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        aluop1_i,
    input  logic        aluop0_i,
    input  logic [3:0]  funct_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] pc_i,
    input  logic [15:0] imm16_i,
    output logic [2:0]  gout_o,
    output logic [31:0] result_o,
    output logic        zero_o,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] branch_target_o,
    output logic [31:0] result_q_o,
    output logic        zero_q_o
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic [31:0] diff;
    logic [31:0] result_d;
    logic        zero_d;
    logic [31:0] result_q;
    logic        zero_q;

    // Later funct rules override earlier ones, so test them in reverse priority.
    always_comb begin
        gout_o = aluop0_i ? OP_SUB : OP_ADD;
        if (aluop1_i) begin
            if (funct_i[2] && !funct_i[0]) begin
                gout_o = OP_AND;
            end else if (funct_i[2] && funct_i[0]) begin
                gout_o = OP_OR;
            end else if (funct_i[1] && !funct_i[3]) begin
                gout_o = OP_SUB;
            end else if (funct_i[3] && funct_i[1]) begin
                gout_o = OP_SLT;
            end else if (funct_i == 4'b0000) begin
                gout_o = OP_ADD;
            end
        end
    end

    assign diff = a_i + ~b_i + 32'd1;

    // slt takes the raw sign of the wrapped difference, without overflow correction.
    always_comb begin
        result_d = 32'd0;
        case (gout_o)
            OP_AND:  result_d = a_i & b_i;
            OP_OR:   result_d = a_i | b_i;
            OP_ADD:  result_d = a_i + b_i;
            OP_SUB:  result_d = diff;
            OP_SLT:  result_d = {31'd0, diff[31]};
            default: result_d = 32'd0;
        endcase
    end

    assign zero_d          = ~|result_d;
    assign result_o        = result_d;
    assign zero_o          = zero_d;
    assign pc_plus4_o      = pc_i + 32'd4;
    assign branch_target_o = pc_plus4_o + {{14{imm16_i[15]}}, imm16_i, 2'b00};

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            result_q <= 32'd0;
            zero_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign result_q_o = result_q;
    assign zero_q_o   = zero_q;

endmodule

// File: tb/tb_mips_alu_exec_unit.sv
// Directed and randomized checks of mips_alu_exec_unit against an arithmetic reference model.
module tb_mips_alu_exec_unit;

    logic        clk;
    logic        rst_n;
    logic        aluop1, aluop0;
    logic [3:0]  funct;
    logic [31:0] a, b, pc;
    logic [15:0] imm16;
    logic [2:0]  gout;
    logic [31:0] result, pc_plus4, branch_target, result_q;
    logic        zero, zero_q;

    int tests = 0;
    int fails = 0;

    mips_alu_exec_unit dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .aluop1_i       (aluop1),
        .aluop0_i       (aluop0),
        .funct_i        (funct),
        .a_i            (a),
        .b_i            (b),
        .pc_i           (pc),
        .imm16_i        (imm16),
        .gout_o         (gout),
        .result_o       (result),
        .zero_o         (zero),
        .pc_plus4_o     (pc_plus4),
        .branch_target_o(branch_target),
        .result_q_o     (result_q),
        .zero_q_o       (zero_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] ref_gout(input logic op1, input logic op0, input logic [3:0] f);
        logic [2:0] g;
        g = op0 ? 3'd6 : 3'd2;
        if (op1) begin
            if (f == 4'd0)         g = 3'd2;
            if (f[3] && f[1])      g = 3'd7;
            if (f[1] && !f[3])     g = 3'd6;
            if (f[2] && f[0])      g = 3'd1;
            if (f[2] && !f[0])     g = 3'd0;
        end
        return g;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] g, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] d;
        d = x - y;
        case (g)
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd2:    return x + y;
            3'd6:    return d;
            3'd7:    return ($signed(d) < 0) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_bt(input logic [31:0] p, input logic [15:0] i);
        int signed off;
        off = $signed(i) * 4;
        return p + 32'd4 + off;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic op1, input logic op0, input logic [3:0] f,
                         input logic [31:0] x, input logic [31:0] y);
        aluop1 = op1; aluop0 = op0; funct = f; a = x; b = y;
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [2:0]  g;
        logic [31:0] r;
        g = ref_gout(aluop1, aluop0, funct);
        r = ref_alu(g, a, b);
        check({tag, "_gout"}, {29'd0, gout}, {29'd0, g});
        check({tag, "_result"}, result, r);
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, (r == 32'd0)});
        check({tag, "_pc4"}, pc_plus4, pc + 32'd4);
        check({tag, "_bt"}, branch_target, ref_bt(pc, imm16));
    endtask

    initial begin
        logic [31:0] exp_r;
        logic        exp_z;

        rst_n = 1'b0; pc = 32'd0; imm16 = 16'd0;
        drive(1'b0, 1'b0, 4'd0, 32'd2, 32'd3);
        repeat (2) @(posedge clk);
        #1;
        check("rst_result_q", result_q, 32'd0);
        check("rst_zero_q", {31'd0, zero_q}, 32'd0);
        check("rst_comb_live", result, 32'd5);

        // decode sweep
        drive(1'b0, 1'b0, 4'b1111, 32'd0, 32'd0); check("dec_00", {29'd0, gout}, 32'd2);
        drive(1'b0, 1'b1, 4'b1111, 32'd0, 32'd0); check("dec_01", {29'd0, gout}, 32'd6);
        drive(1'b1, 1'b0, 4'b0000, 32'd0, 32'd0); check("dec_add", {29'd0, gout}, 32'd2);
        drive(1'b1, 1'b0, 4'b0010, 32'd0, 32'd0); check("dec_sub", {29'd0, gout}, 32'd6);
        drive(1'b1, 1'b0, 4'b0100, 32'd0, 32'd0); check("dec_and", {29'd0, gout}, 32'd0);
        drive(1'b1, 1'b0, 4'b0101, 32'd0, 32'd0); check("dec_or", {29'd0, gout}, 32'd1);
        drive(1'b1, 1'b0, 4'b1010, 32'd0, 32'd0); check("dec_slt", {29'd0, gout}, 32'd7);
        drive(1'b1, 1'b0, 4'b1000, 32'd0, 32'd0); check("dec_nomatch", {29'd0, gout}, 32'd2);
        drive(1'b1, 1'b1, 4'b0001, 32'd0, 32'd0); check("dec_11_keep", {29'd0, gout}, 32'd6);

        // arithmetic
        drive(1'b0, 1'b0, 4'd0, 32'h7FFFFFFF, 32'h1);
        check("add_ovf", result, 32'h80000000); check("add_ovf_z", {31'd0, zero}, 32'd0);
        drive(1'b0, 1'b1, 4'd0, 32'd5, 32'd5);
        check("sub_eq", result, 32'd0); check("sub_eq_z", {31'd0, zero}, 32'd1);
        drive(1'b0, 1'b0, 4'd0, 32'hFFFFFFFF, 32'h1);
        check("add_wrap", result, 32'd0); check("add_wrap_z", {31'd0, zero}, 32'd1);

        // logic and slt
        drive(1'b1, 1'b0, 4'b0100, 32'hF0F0F0F0, 32'h0FF00FF0); check("and", result, 32'h00F000F0);
        drive(1'b1, 1'b0, 4'b0101, 32'hF0F0F0F0, 32'h0FF00FF0); check("or", result, 32'hFFF0FFF0);
        drive(1'b1, 1'b0, 4'b1010, 32'hFFFFFFFE, 32'h1);        check("slt_neg", result, 32'd1);
        drive(1'b1, 1'b0, 4'b1010, 32'd3, 32'd2);               check("slt_gt", result, 32'd0);
        drive(1'b1, 1'b0, 4'b1010, 32'h80000000, 32'h1);        check("slt_noovf", result, 32'd0);

        // adders
        pc = 32'd0; imm16 = 16'h0003; #1;
        check("pc4_0", pc_plus4, 32'd4); check("bt_fwd", branch_target, 32'h10);
        pc = 32'h20; imm16 = 16'hFFFE; #1;
        check("pc4_20", pc_plus4, 32'h24); check("bt_back", branch_target, 32'h1C);
        pc = 32'hFFFFFFFC; #1;
        check("pc4_wrap", pc_plus4, 32'd0);

        // register / reset sequencing
        @(negedge clk); rst_n = 1'b1; drive(1'b0, 1'b1, 4'd0, 32'd9, 32'd9);
        @(posedge clk); #1;
        check("rel_result_q", result_q, 32'd0); check("rel_zero_q", {31'd0, zero_q}, 32'd1);
        @(negedge clk); drive(1'b0, 1'b0, 4'd0, 32'd2, 32'd3);
        @(posedge clk); #1;
        check("cap_result_q", result_q, 32'd5); check("cap_zero_q", {31'd0, zero_q}, 32'd0);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_result_q", result_q, 32'd0); check("mid_rst_zero_q", {31'd0, zero_q}, 32'd0);
        check("mid_rst_comb", result, 32'd5);

        // randomized against the reference model, including the registered path
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            pc    = $urandom;
            imm16 = 16'($urandom);
            drive(1'($urandom), 1'($urandom), 4'($urandom), $urandom,
                  (i % 5 == 0) ? a : 32'($urandom));
            if (i % 7 == 0) b = a;
            #1;
            check_model("rnd");
            exp_r = ref_alu(ref_gout(aluop1, aluop0, funct), a, b);
            exp_z = (exp_r == 32'd0);
            @(posedge clk); #1;
            check("rnd_result_q", result_q, exp_r);
            check("rnd_zero_q", {31'd0, zero_q}, {31'd0, exp_z});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
